// File: rtl/sys_arr_result_collector_if.sv
// Result-row output stream of the systolic-array result collector.
//   out_row   : aligned result row, column c at bits [16c+15:16c]
//   out_valid : out_row holds an unconsumed row
//   out_ready : consumer accepts the row when high together with out_valid
// master = collector side, slave = consumer side.
interface sys_arr_result_collector_if #(
  parameter int width_height = 2
) ();
  logic [16*width_height-1:0] out_row;
  logic                       out_valid;
  logic                       out_ready;

  modport master (output out_row, output out_valid, input out_ready);
  modport slave  (input out_row, input out_valid, output out_ready);
endinterface

// File: rtl/sys_arr_result_collector.sv
// Re-assembles the skewed bottom-row sums of the systolic array into aligned
// result rows. Each column has its own FIFO lane, so the array skew is absorbed
// without per-column delay lines; a row is emitted once every lane holds a word.
//   clock, reset_n : sole clock (rising edge), asynchronous active-low reset
//   maccout        : bottom-row sums, column c at bits [16c+15:16c]
//   activeout      : bit c high = column c word valid this cycle
//   clear          : synchronous flush of lanes, output stage and overflow
//   out_if         : result-row valid/ready stream (master side)
//   overflow       : sticky, at least one word dropped on a full lane
//   rows_out       : rows transferred, wraps at 2^16
module sys_arr_result_collector #(
  parameter int width_height = 2,
  parameter int depth        = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [16*width_height-1:0] maccout,
  input  logic [width_height-1:0]    activeout,
  input  logic                       clear,
  sys_arr_result_collector_if.master out_if,
  output logic                       overflow,
  output logic [15:0]                rows_out
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = aw + 1;

  typedef logic [aw-1:0] ptr_t;
  typedef logic [cw-1:0] cnt_t;

  logic [15:0] mem    [width_height][depth];
  ptr_t        wr_ptr [width_height];
  ptr_t        rd_ptr [width_height];
  cnt_t        count  [width_height];

  logic [width_height-1:0]    lane_nonempty;
  logic [width_height-1:0]    lane_full;
  logic [width_height-1:0]    push;
  logic [width_height-1:0]    drop;
  logic [16*width_height-1:0] head_row;
  logic                       rows_avail;
  logic                       load;
  logic                       xfer;

  always_comb begin
    lane_nonempty = '0;
    lane_full     = '0;
    push          = '0;
    drop          = '0;
    head_row      = '0;
    for (int unsigned c = 0; c < width_height; c++) begin
      lane_nonempty[c]    = (count[c] != '0);
      lane_full[c]        = (count[c] == cnt_t'(depth));
      head_row[16*c +: 16] = mem[c][rd_ptr[c]];
    end
    rows_avail = &lane_nonempty;
    // out_ready feeds the pop decision; it never reaches out_valid combinationally.
    load = rows_avail & (~out_if.out_valid | out_if.out_ready);
    xfer = out_if.out_valid & out_if.out_ready;
    // A full lane still accepts a write when it is popped in the same cycle.
    for (int unsigned c = 0; c < width_height; c++) begin
      push[c] = activeout[c] & (~lane_full[c] | load);
      drop[c] = activeout[c] & lane_full[c] & ~load;
    end
  end

  // Lane storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (reset_n && !clear) begin
      for (int unsigned c = 0; c < width_height; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= maccout[16*c +: 16];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < width_height; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else if (clear) begin
      for (int unsigned c = 0; c < width_height; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < width_height; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + ptr_t'(1);
        end
        if (load) begin
          rd_ptr[c] <= rd_ptr[c] + ptr_t'(1);
        end
        case ({push[c], load})
          2'b10:   count[c] <= count[c] + cnt_t'(1);
          2'b01:   count[c] <= count[c] - cnt_t'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_if.out_row   <= '0;
      out_if.out_valid <= 1'b0;
      overflow         <= 1'b0;
      rows_out         <= '0;
    end else if (clear) begin
      // out_row keeps its last value; rows_out is a lifetime count.
      out_if.out_valid <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (load) begin
        out_if.out_row   <= head_row;
        out_if.out_valid <= 1'b1;
      end else if (xfer) begin
        out_if.out_valid <= 1'b0;
      end
      if (xfer) begin
        rows_out <= rows_out + 16'd1;
      end
      if (|drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_arr_result_collector.sv
// Self-checking bench for sys_arr_result_collector: directed scenarios plus a
// randomized phase, all compared against a queue-based row model.
module tb_sys_arr_result_collector;
  localparam int W = 2;
  localparam int D = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           clear;
  logic [16*W-1:0] maccout;
  logic [W-1:0]   activeout;
  logic           overflow;
  logic [15:0]    rows_out;

  sys_arr_result_collector_if #(.width_height(W)) out_if ();

  sys_arr_result_collector #(.width_height(W), .depth(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .maccout   (maccout),
    .activeout (activeout),
    .clear     (clear),
    .out_if    (out_if),
    .overflow  (overflow),
    .rows_out  (rows_out)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: one word queue per column plus the output register.
  logic [15:0]     mq [W][$];
  logic            m_valid;
  logic [16*W-1:0] m_row;
  logic            m_ovf;
  logic [15:0]     m_rows;

  function automatic void model_reset();
    for (int c = 0; c < W; c++) mq[c].delete();
    m_valid = 1'b0;
    m_row   = '0;
    m_ovf   = 1'b0;
    m_rows  = '0;
  endfunction

  // Next state from current state and the inputs presented before the edge.
  function automatic void model_clock();
    bit avail;
    bit ld;
    bit take;
    if (clear) begin
      for (int c = 0; c < W; c++) mq[c].delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      return;
    end
    avail = 1'b1;
    for (int c = 0; c < W; c++) if (mq[c].size() == 0) avail = 1'b0;
    take = m_valid && out_if.out_ready;
    ld   = avail && (!m_valid || out_if.out_ready);
    if (take) m_rows = m_rows + 16'd1;
    if (ld) begin
      for (int c = 0; c < W; c++) m_row[16*c +: 16] = mq[c].pop_front();
      m_valid = 1'b1;
    end else if (take) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < W; c++) begin
      if (activeout[c]) begin
        if (mq[c].size() < D) mq[c].push_back(maccout[16*c +: 16]);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    chk({tag, ".out_valid"}, 64'(out_if.out_valid), 64'(m_valid));
    chk({tag, ".out_row"},   64'(out_if.out_row),   64'(m_row));
    chk({tag, ".overflow"},  64'(overflow),         64'(m_ovf));
    chk({tag, ".rows_out"},  64'(rows_out),         64'(m_rows));
  endtask

  task automatic cycle(input string tag);
    model_clock();
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic rand_data();
    for (int c = 0; c < W; c++) maccout[16*c +: 16] = 16'($urandom);
  endtask

  task automatic idle(input int n, input string tag);
    activeout = '0;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // n rows, column c of row r presented at step r+c (array skew).
  task automatic stream(input int n, input string tag);
    for (int k = 0; k < n + W - 1; k++) begin
      rand_data();
      activeout = '0;
      for (int c = 0; c < W; c++) if (k >= c && k - c < n) activeout[c] = 1'b1;
      cycle(tag);
    end
    activeout = '0;
  endtask

  initial begin
    logic [15:0]     r0;
    logic [16*W-1:0] held;

    reset_n          = 1'b0;
    clear            = 1'b0;
    activeout        = '0;
    maccout          = '0;
    out_if.out_ready = 1'b1;
    model_reset();
    #12;
    check("reset");
    reset_n = 1'b1;

    // Basic skewed row.
    maccout = '0; maccout[15:0] = 16'h0011; activeout = 2'b01; cycle("basic");
    maccout = '0; maccout[31:16] = 16'h0022; activeout = 2'b10; cycle("basic");
    activeout = '0; cycle("basic");
    chk("basic.valid", 64'(out_if.out_valid), 64'd1);
    chk("basic.row", 64'(out_if.out_row), 64'h0000_0000_0022_0011);
    cycle("basic");
    chk("basic.rows_out", 64'(rows_out), 64'd1);

    // Backpressure: first row stays put, the rest wait in the lanes.
    out_if.out_ready = 1'b0;
    r0 = rows_out;
    stream(4, "bp");
    held = out_if.out_row;
    idle(2, "bp");
    chk("bp.stable", 64'(out_if.out_row), 64'(held));
    chk("bp.no_ovf", 64'(overflow), 64'd0);
    out_if.out_ready = 1'b1;
    idle(6, "bp_drain");
    chk("bp.rows", 64'(rows_out), 64'(r0 + 16'd4));

    // Overflow: sixth row dropped, the first five drain intact.
    out_if.out_ready = 1'b0;
    r0 = rows_out;
    stream(6, "ovf");
    chk("ovf.set", 64'(overflow), 64'd1);
    idle(3, "ovf_hold");
    chk("ovf.sticky", 64'(overflow), 64'd1);
    out_if.out_ready = 1'b1;
    idle(8, "ovf_drain");
    chk("ovf.rows", 64'(rows_out), 64'(r0 + 16'd5));

    // Clear with rows buffered and overflow set; the clear-cycle word is lost.
    out_if.out_ready = 1'b0;
    stream(2, "clr_fill");
    r0 = rows_out;
    rand_data();
    activeout = 2'b11;
    clear = 1'b1;
    cycle("clr");
    clear = 1'b0;
    chk("clr.valid", 64'(out_if.out_valid), 64'd0);
    chk("clr.ovf", 64'(overflow), 64'd0);
    chk("clr.rows", 64'(rows_out), 64'(r0));
    out_if.out_ready = 1'b1;
    idle(3, "clr_empty");
    chk("clr.empty", 64'(out_if.out_valid), 64'd0);

    // Full lanes popped and written in the same cycle: no drop, still full.
    out_if.out_ready = 1'b0;
    stream(5, "full_fill");
    rand_data();
    activeout = 2'b11;
    out_if.out_ready = 1'b1;
    cycle("full_pop");
    chk("full_pop.no_ovf", 64'(overflow), 64'd0);
    rand_data();
    activeout = 2'b11;
    out_if.out_ready = 1'b0;
    cycle("full_again");
    chk("full_again.ovf", 64'(overflow), 64'd1);
    out_if.out_ready = 1'b1;
    idle(7, "full_drain");

    // Asynchronous reset mid-stream.
    rand_data(); activeout = 2'b01; cycle("arst_pre");
    rand_data(); activeout = 2'b11; cycle("arst_pre");
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", 64'(out_if.out_valid), 64'd0);
    chk("arst.row", 64'(out_if.out_row), 64'd0);
    chk("arst.ovf", 64'(overflow), 64'd0);
    chk("arst.rows", 64'(rows_out), 64'd0);
    #1;
    reset_n = 1'b1;
    maccout = '0; maccout[15:0] = 16'hA5A5; activeout = 2'b01; cycle("arst_row");
    maccout = '0; maccout[31:16] = 16'h5A5A; activeout = 2'b10; cycle("arst_row");
    activeout = '0; cycle("arst_row");
    chk("arst.fresh", 64'(out_if.out_row), 64'h0000_0000_5A5A_A5A5);
    idle(2, "arst_row");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      activeout        = W'($urandom);
      out_if.out_ready = ($urandom_range(0, 3) != 0);
      clear            = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    clear = 1'b0;
    out_if.out_ready = 1'b1;
    idle(8, "rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
